// File: rtl/spi_duty_pkg.sv
// ============================================================================
// Module      : spi_duty_pkg
// Description : Shared constants and state encoding for the SPI duty receiver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_duty_pkg;

    localparam logic [3:0] CMD_SET    = 4'hA;
    localparam logic [3:0] CMD_READ   = 4'h5;
    localparam logic [3:0] MISO_HDR   = 4'hC;
    localparam int         FRAME_BITS = 8;

    // Bit counter stops here so over-long frames stay distinguishable from 8.
    localparam logic [3:0] CNT_SAT    = 4'd9;

    typedef enum logic [1:0] {
        WAIT_IDLE = 2'd0,
        IDLE      = 2'd1,
        SHIFT     = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
// Module      : sync_edge
// Description : Multi-stage input synchronizer with registered level/edge out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] r_sync_q;
    logic                   r_level_q;
    logic                   r_rise_q;
    logic                   r_fall_q;
    logic                   w_sync_out;

    assign w_sync_out = r_sync_q[SYNC_STAGES-1];

    // Level and edges come out of the same register stage so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_q  <= '0;
            r_level_q <= 1'b0;
            r_rise_q  <= 1'b0;
            r_fall_q  <= 1'b0;
        end else begin
            r_sync_q  <= {r_sync_q[SYNC_STAGES-2:0], d_i};
            r_level_q <= w_sync_out;
            r_rise_q  <= w_sync_out & ~r_level_q;
            r_fall_q  <= ~w_sync_out & r_level_q;
        end
    end

    assign level_o = r_level_q;
    assign rise_o  = r_rise_q;
    assign fall_o  = r_fall_q;

endmodule

`default_nettype wire

// File: rtl/spi_duty_receiver.sv
// ============================================================================
// Module      : spi_duty_receiver
// Description : SPI mode-0 slave that validates command frames and holds the
//               PWM duty value; echoes the current duty on MISO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_duty_receiver
    import spi_duty_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DUTY_MAX    = 10
) (
    input  logic       SLK,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [3:0] Porcentaje,
    output logic       frame_valid,
    output logic       frame_error
);

    localparam logic [3:0] c_DUTY_MAX = 4'(DUTY_MAX);
    localparam logic [3:0] c_FRAME_BITS = 4'(FRAME_BITS);

    logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
    logic w_cs_lvl, w_cs_rise, w_cs_fall;
    logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;
    logic w_unused_edges;

    state_t     r_state_q, w_state_d;
    logic [3:0] r_cnt_q, w_cnt_d;
    logic [7:0] r_rx_q, w_rx_d;
    logic [7:0] r_tx_q, w_tx_d;
    logic [3:0] r_duty_q, w_duty_d;
    logic       r_miso_q, w_miso_d;
    logic       r_valid_q, w_valid_d;
    logic       r_error_q, w_error_d;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(SLK), .rst(rst), .d_i(spi_sclk),
        .level_o(w_sclk_lvl), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(SLK), .rst(rst), .d_i(spi_cs_n),
        .level_o(w_cs_lvl), .rise_o(w_cs_rise), .fall_o(w_cs_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(SLK), .rst(rst), .d_i(spi_mosi),
        .level_o(w_mosi_lvl), .rise_o(w_mosi_rise), .fall_o(w_mosi_fall)
    );

    assign w_unused_edges = w_sclk_lvl ^ w_mosi_rise ^ w_mosi_fall;

    // SCLK work is applied first so a CS rise in the same cycle sees the final bit.
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_rx_d    = r_rx_q;
        w_tx_d    = r_tx_q;
        w_duty_d  = r_duty_q;
        w_valid_d = 1'b0;
        w_error_d = 1'b0;
        case (r_state_q)
            WAIT_IDLE: begin
                if (w_cs_lvl) w_state_d = IDLE;
            end
            IDLE: begin
                if (w_cs_fall) begin
                    w_cnt_d   = 4'd0;
                    w_tx_d    = {MISO_HDR, r_duty_q};
                    w_state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (w_sclk_rise) begin
                    w_rx_d = {r_rx_q[6:0], w_mosi_lvl};
                    if (r_cnt_q != CNT_SAT) w_cnt_d = r_cnt_q + 4'd1;
                end
                if (w_sclk_fall) w_tx_d = {r_tx_q[6:0], 1'b0};
                if (w_cs_rise) begin
                    w_state_d = IDLE;
                    if (w_cnt_d == c_FRAME_BITS) begin
                        case (w_rx_d[7:4])
                            CMD_SET: begin
                                if (w_rx_d[3:0] <= c_DUTY_MAX) begin
                                    w_duty_d  = w_rx_d[3:0];
                                    w_valid_d = 1'b1;
                                end else begin
                                    w_error_d = 1'b1;
                                end
                            end
                            CMD_READ: w_valid_d = 1'b1;
                            default:  w_error_d = 1'b1;
                        endcase
                    end else begin
                        w_error_d = 1'b1;
                    end
                end
            end
            default: w_state_d = WAIT_IDLE;
        endcase
        w_miso_d = (w_state_d == SHIFT) ? w_tx_d[7] : 1'b0;
    end

    always_ff @(posedge SLK) begin
        if (rst) begin
            r_state_q <= WAIT_IDLE;
            r_cnt_q   <= 4'd0;
            r_rx_q    <= 8'd0;
            r_tx_q    <= 8'd0;
            r_duty_q  <= 4'd0;
            r_miso_q  <= 1'b0;
            r_valid_q <= 1'b0;
            r_error_q <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_rx_q    <= w_rx_d;
            r_tx_q    <= w_tx_d;
            r_duty_q  <= w_duty_d;
            r_miso_q  <= w_miso_d;
            r_valid_q <= w_valid_d;
            r_error_q <= w_error_d;
        end
    end

    assign spi_miso    = r_miso_q;
    assign Porcentaje  = r_duty_q;
    assign frame_valid = r_valid_q;
    assign frame_error = r_error_q;

endmodule

`default_nettype wire
